// File: rtl/wbm16_seq.sv
`default_nettype none
// ============================================================================
//  Module   : wbm16_seq
//  Purpose  : Wishbone initiator for the 16-bit register bus. Turns single
//             register commands (valid/ready) into classic Wishbone single
//             cycles and returns read data or a timeout error over a
//             response valid/ready handshake.
//  Ports    : wb_clk, wb_rst_n             clock, async active-low reset
//             cmd_valid/ready/we/adr/dat   command handshake and payload
//             rsp_valid/ready/dat/err      response handshake and payload
//             wb_cyc/stb/we/adr/dat_o      Wishbone initiator outputs
//             wb_dat_i, wb_ack             Wishbone slave returns
//             err_cnt                      saturating timeout count
//  Revision : 1.0  initial release
// ============================================================================
module wbm16_seq #(
    parameter int ADRBITS = 4,
    parameter int TMOBITS = 8
) (
    input  logic               wb_clk,
    input  logic               wb_rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_we,
    input  logic [ADRBITS-1:0] cmd_adr,
    input  logic [15:0]        cmd_dat,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [15:0]        rsp_dat,
    output logic               rsp_err,
    output logic               wb_cyc,
    output logic               wb_stb,
    output logic               wb_we,
    output logic [ADRBITS-1:0] wb_adr,
    output logic [15:0]        wb_dat_o,
    input  logic [15:0]        wb_dat_i,
    input  logic               wb_ack,
    output logic [7:0]         err_cnt
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CYC  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Counter value at which the next ack-less edge is the last one allowed;
    // the strobe then stays high for exactly 2**TMOBITS-1 cycles.
    localparam logic [TMOBITS-1:0] TMO_LAST = ~TMOBITS'(1);

    logic [1:0]         state_q, state_d;
    logic [TMOBITS-1:0] tmo_q, tmo_d;
    logic               cyc_q, cyc_d;
    logic               we_q, we_d;
    logic [ADRBITS-1:0] adr_q, adr_d;
    logic [15:0]        dato_q, dato_d;
    logic               rspv_q, rspv_d;
    logic [15:0]        rspd_q, rspd_d;
    logic               rspe_q, rspe_d;
    logic [7:0]         errc_q, errc_d;

    logic w_accept;
    logic w_timeout;

    assign w_accept  = cmd_valid && (state_q == ST_IDLE);
    // Ack has priority: a timeout only counts when no ack is sampled.
    assign w_timeout = (state_q == ST_CYC) && !wb_ack && (tmo_q == TMO_LAST);

    // State register
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. wb_ack is only looked at in CYC, so the stale ack
    // that follows every completed cycle is ignored in RESP and IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (w_accept)             state_d = ST_CYC;
            ST_CYC:  if (wb_ack || w_timeout)  state_d = ST_RESP;
            ST_RESP: if (rsp_ready)            state_d = ST_IDLE;
            default:                           state_d = ST_IDLE;
        endcase
    end

    // Output / datapath next values (all registered below)
    always_comb begin
        tmo_d  = tmo_q;
        cyc_d  = cyc_q;
        we_d   = we_q;
        adr_d  = adr_q;
        dato_d = dato_q;
        rspv_d = rspv_q;
        rspd_d = rspd_q;
        rspe_d = rspe_q;
        errc_d = errc_q;
        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    we_d   = cmd_we;
                    adr_d  = cmd_adr;
                    dato_d = cmd_dat;
                    cyc_d  = 1'b1;
                    tmo_d  = '0;
                end
            end
            ST_CYC: begin
                if (wb_ack) begin
                    rspd_d = wb_dat_i;
                    rspe_d = 1'b0;
                    cyc_d  = 1'b0;
                    rspv_d = 1'b1;
                end else if (w_timeout) begin
                    rspd_d = 16'hFFFF;
                    rspe_d = 1'b1;
                    cyc_d  = 1'b0;
                    rspv_d = 1'b1;
                    if (errc_q != 8'hFF) begin
                        errc_d = errc_q + 8'd1;
                    end
                end else begin
                    tmo_d = tmo_q + TMOBITS'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rspv_d = 1'b0;
                end
            end
            default: begin
                cyc_d  = 1'b0;
                rspv_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            tmo_q  <= '0;
            cyc_q  <= 1'b0;
            we_q   <= 1'b0;
            adr_q  <= '0;
            dato_q <= 16'h0000;
            rspv_q <= 1'b0;
            rspd_q <= 16'h0000;
            rspe_q <= 1'b0;
            errc_q <= 8'h00;
        end else begin
            tmo_q  <= tmo_d;
            cyc_q  <= cyc_d;
            we_q   <= we_d;
            adr_q  <= adr_d;
            dato_q <= dato_d;
            rspv_q <= rspv_d;
            rspd_q <= rspd_d;
            rspe_q <= rspe_d;
            errc_q <= errc_d;
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign rsp_valid = rspv_q;
    assign rsp_dat   = rspd_q;
    assign rsp_err   = rspe_q;
    assign wb_cyc    = cyc_q;
    assign wb_stb    = cyc_q;
    assign wb_we     = we_q;
    assign wb_adr    = adr_q;
    assign wb_dat_o  = dato_q;
    assign err_cnt   = errc_q;

endmodule
`default_nettype wire

// File: tb/tb_wbm16_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wbm16_seq
//  Purpose  : Directed self-checking bench for wbm16_seq with a small
//             register-slave model (registered ack = cyc & stb).
//  Revision : 1.0  initial release
// ============================================================================
module tb_wbm16_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [3:0]  cmd_adr;
    logic [15:0] cmd_dat;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [15:0] rsp_dat;
    logic        wb_cyc, wb_stb, wb_we, wb_ack;
    logic [3:0]  wb_adr;
    logic [15:0] wb_dat_o, wb_dat_i;
    logic [7:0]  err_cnt;

    int n_asrt = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    wbm16_seq #(.ADRBITS(4), .TMOBITS(8)) dut (
        .wb_clk    (clk),
        .wb_rst_n  (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_adr   (cmd_adr),
        .cmd_dat   (cmd_dat),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_dat   (rsp_dat),
        .rsp_err   (rsp_err),
        .wb_cyc    (wb_cyc),
        .wb_stb    (wb_stb),
        .wb_we     (wb_we),
        .wb_adr    (wb_adr),
        .wb_dat_o  (wb_dat_o),
        .wb_dat_i  (wb_dat_i),
        .wb_ack    (wb_ack),
        .err_cnt   (err_cnt)
    );

    // Slave model: single-wait register slave, disabled to force timeouts.
    logic        slv_en;
    logic [15:0] mem [0:15];

    always_ff @(posedge clk) begin
        wb_ack <= wb_cyc & wb_stb & slv_en;
        if (wb_cyc && wb_stb && wb_we && slv_en) begin
            mem[wb_adr] <= wb_dat_o;
        end
    end
    assign wb_dat_i = slv_en ? mem[wb_adr] : 16'h0000;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one command for a single edge, then count strobe-high samples
    // until a response appears (bounded).
    task automatic run_cmd(input logic we, input logic [3:0] adr,
                           input logic [15:0] dat, output int n);
        int guard;
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_adr   = adr;
        cmd_dat   = dat;
        tick();
        cmd_valid = 1'b0;
        n     = 0;
        guard = 0;
        while (!rsp_valid && guard < 400) begin
            if (wb_stb) n++;
            guard++;
            tick();
        end
    endtask

    task automatic take_rsp();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    int n;

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_adr   = 4'h0;
        cmd_dat   = 16'h0000;
        rsp_ready = 1'b0;
        slv_en    = 1'b1;
        tick();
        tick();
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_stb",       32'(wb_stb),    32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_err_cnt",   32'(err_cnt),   32'd0);
        rst_n = 1'b1;
        tick();

        // Write 0x1234 to adr 3
        check("wr_cmd_ready", 32'(cmd_ready), 32'd1);
        run_cmd(1'b1, 4'd3, 16'h1234, n);
        check("wr_stb_cycles", 32'(n),         32'd2);
        check("wr_rsp_valid",  32'(rsp_valid), 32'd1);
        check("wr_rsp_err",    32'(rsp_err),   32'd0);
        check("wr_we_hold",    32'(wb_we),     32'd1);
        check("wr_adr_hold",   32'(wb_adr),    32'd3);
        check("wr_dato_hold",  32'(wb_dat_o),  32'h1234);
        take_rsp();
        check("wr_rsp_clear",  32'(rsp_valid), 32'd0);
        check("wr_cmd_ready2", 32'(cmd_ready), 32'd1);

        // Read back adr 3
        run_cmd(1'b0, 4'd3, 16'h0000, n);
        check("rd_stb_cycles", 32'(n),         32'd2);
        check("rd_rsp_valid",  32'(rsp_valid), 32'd1);
        check("rd_rsp_dat",    32'(rsp_dat),   32'h1234);
        check("rd_rsp_err",    32'(rsp_err),   32'd0);
        check("rd_we",         32'(wb_we),     32'd0);
        check("rd_stale_ack",  32'(wb_ack),    32'd1);
        take_rsp();
        tick();
        check("rd_no_2nd_rsp", 32'(rsp_valid), 32'd0);
        check("rd_no_2nd_stb", 32'(wb_stb),    32'd0);

        // Asynchronous reset with a response pending, between clock edges
        run_cmd(1'b1, 4'd7, 16'h5A5A, n);
        check("ar_rsp_valid_pre", 32'(rsp_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_rsp_valid", 32'(rsp_valid), 32'd0);
        check("ar_rsp_dat",   32'(rsp_dat),   32'd0);
        check("ar_we",        32'(wb_we),     32'd0);
        check("ar_adr",       32'(wb_adr),    32'd0);
        check("ar_dato",      32'(wb_dat_o),  32'd0);
        check("ar_cmd_ready", 32'(cmd_ready), 32'd1);
        #2;
        rst_n = 1'b1;
        tick();

        // Backpressure: response held with a new command waiting
        run_cmd(1'b0, 4'd3, 16'h0000, n);
        cmd_valid = 1'b1;
        cmd_we    = 1'b1;
        cmd_adr   = 4'd5;
        cmd_dat   = 16'hBEEF;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rsp_dat",   32'(rsp_dat),   32'h1234);
            check("bp_rsp_err",   32'(rsp_err),   32'd0);
            check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
            check("bp_no_stb",    32'(wb_stb),    32'd0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("bp_hs_rsp_valid", 32'(rsp_valid), 32'd0);
        check("bp_hs_cmd_ready", 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
        check("bp_acc_stb", 32'(wb_stb),   32'd1);
        check("bp_acc_adr", 32'(wb_adr),   32'd5);
        check("bp_acc_dat", 32'(wb_dat_o), 32'hBEEF);
        check("bp_acc_we",  32'(wb_we),    32'd1);
        for (int g = 0; g < 10 && !rsp_valid; g++) tick();
        check("bp_done_rsp", 32'(rsp_valid), 32'd1);
        take_rsp();

        // Timeout
        slv_en = 1'b0;
        run_cmd(1'b0, 4'd2, 16'h0000, n);
        check("to_stb_cycles", 32'(n),         32'd255);
        check("to_rsp_valid",  32'(rsp_valid), 32'd1);
        check("to_rsp_err",    32'(rsp_err),   32'd1);
        check("to_rsp_dat",    32'(rsp_dat),   32'hFFFF);
        check("to_err_cnt",    32'(err_cnt),   32'd1);
        check("to_stb_low",    32'(wb_stb),    32'd0);
        take_rsp();

        // 256 more timeouts: counter must saturate at 255
        for (int i = 0; i < 256; i++) begin
            run_cmd(1'b0, 4'd2, 16'h0000, n);
            take_rsp();
        end
        check("sat_stb_cycles", 32'(n),       32'd255);
        check("sat_err_cnt",    32'(err_cnt), 32'd255);

        // Reset in the middle of a bus cycle
        cmd_valid = 1'b1;
        cmd_we    = 1'b1;
        cmd_adr   = 4'd9;
        cmd_dat   = 16'h7777;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        check("mr_stb_pre", 32'(wb_stb), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mr_cyc",       32'(wb_cyc),    32'd0);
        check("mr_stb",       32'(wb_stb),    32'd0);
        check("mr_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mr_err_cnt",   32'(err_cnt),   32'd0);
        check("mr_cmd_ready", 32'(cmd_ready), 32'd1);
        tick();
        rst_n  = 1'b1;
        slv_en = 1'b1;
        tick();
        check("mr_no_rsp", 32'(rsp_valid), 32'd0);

        run_cmd(1'b1, 4'd1, 16'hA5A5, n);
        check("mr_wr_stb_cycles", 32'(n),         32'd2);
        check("mr_wr_rsp_valid",  32'(rsp_valid), 32'd1);
        check("mr_wr_rsp_err",    32'(rsp_err),   32'd0);
        take_rsp();
        run_cmd(1'b0, 4'd1, 16'h0000, n);
        check("mr_rd_rsp_dat", 32'(rsp_dat), 32'hA5A5);
        take_rsp();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
